// File: rtl/cdb_arbiter_rr.sv
// Common-data-bus arbiter: one registered winner per cycle, round-robin or fixed priority.
// Optional starvation override is compiled in with `define CDB_ARB_AGE_EN.
module cdb_arbiter_rr #(
  parameter int NUM_SRC  = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  input  logic                      stall,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   base;
  logic [PTR_W-1:0]   search_idx;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] grant_next;
  logic               take;

  // A source granted on the previous edge is masked so a late req drop never double-grants.
  assign elig = req & ~grant;
  assign base = (RR_MODE != 0) ? ptr : '0;

  // Search upward from base with wrap; base is zero in fixed mode, giving lowest-index-wins.
  always_comb begin
    rr_found   = 1'b0;
    rr_idx     = '0;
    search_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      search_idx = PTR_W'((int'(base) + k) % NUM_SRC);
      if (!rr_found && elig[search_idx]) begin
        rr_found = 1'b1;
        rr_idx   = search_idx;
      end
    end
  end

`ifdef CDB_ARB_AGE_EN
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0]   age [NUM_SRC];
  logic [NUM_SRC-1:0] urgent;
  logic [PTR_W-1:0]   urg_idx;

  always_comb begin
    urgent  = '0;
    urg_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      urgent[i] = elig[i] && (age[i] >= AGE_MAX);
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (urgent[i]) urg_idx = PTR_W'(i);
    end
  end

  always_comb begin
    win_idx = rr_idx;
    if (|urgent) win_idx = urg_idx;
  end

  // Waiting includes stalled edges; any grant or dropped request clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!req[i] || grant_next[i]) age[i] <= '0;
        else if (age[i] < AGE_MAX)    age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (MAX_WAIT != 0);
  assign win_idx    = rr_idx;
`endif

  assign take     = !stall && rr_found;
  assign ptr_next = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    grant_next = '0;
    if (take) grant_next[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      ptr       <= '0;
    end else if (take) begin
      grant     <= grant_next;
      cdb_valid <= 1'b1;
      cdb_tag   <= req_tag[int'(win_idx)*TAG_W +: TAG_W];
      cdb_data  <= req_data[int'(win_idx)*DATA_W +: DATA_W];
      ptr       <= ptr_next;
    end else begin
      grant     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end
  end

endmodule
